// File: rtl/mem_master_96x8.sv
// -----------------------------------------------------------------------------
// mem_master_96x8
//
// Burst master for a 96x8 synchronous RAM that is mapped at byte addresses
// 128..223. A control unit asks for a 1-4 beat read or write burst with
// req/rw/addr/len. Requests that would touch bytes outside the RAM window are
// rejected before any RAM access. All outputs come straight from flops.
//
// State table
//   state    | meaning
//   ---------+----------------------------------------------------------------
//   ST_IDLE  | waiting for req; range check and accept/reject happen here
//   ST_READ  | issuing read addresses, then collecting RAM data (2-edge lag)
//   ST_WRITE | issuing write beats, pulling wdata through wready
//
// Ports
//   clk            system clock
//   reset          synchronous active-high reset
//   req            transfer request, sampled only while busy=0
//   rw             1=write, 0=read, sampled with req
//   addr[7:0]      start byte address, sampled with req
//   len[1:0]       burst length minus one, sampled with req
//   wdata[7:0]     write data: beat 0 with req, later beats on wready cycles
//   busy           transfer in progress
//   wready         wdata is consumed at the end of this cycle
//   rdata[7:0]     read beat data, held when rvalid=0
//   rvalid         one-cycle pulse per read beat
//   done           one-cycle pulse on completion or rejection
//   err            qualifies done: 1=rejected for range violation
//   mem_address    RAM address (0 whenever no beat is on the bus)
//   mem_WE         RAM write enable
//   mem_data_in    RAM write data
//   mem_data_out   RAM read data, registered one edge after the address
// -----------------------------------------------------------------------------
module mem_master_96x8 (
    input  logic       clk,
    input  logic       reset,
    input  logic       req,
    input  logic       rw,
    input  logic [7:0] addr,
    input  logic [1:0] len,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       wready,
    output logic [7:0] rdata,
    output logic       rvalid,
    output logic       done,
    output logic       err,
    output logic [7:0] mem_address,
    output logic       mem_WE,
    output logic [7:0] mem_data_in,
    input  logic [7:0] mem_data_out
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;

    // r_step = k means the current cycle follows edge Ek of the transfer.
    logic [2:0] r_step;
    logic [2:0] w_step_nxt;
    logic [1:0] r_len;
    logic [1:0] w_len_nxt;

    logic       r_busy,        w_busy_nxt;
    logic       r_wready,      w_wready_nxt;
    logic [7:0] r_rdata,       w_rdata_nxt;
    logic       r_rvalid,      w_rvalid_nxt;
    logic       r_done,        w_done_nxt;
    logic       r_err,         w_err_nxt;
    logic [7:0] r_mem_address, w_mem_address_nxt;
    logic       r_mem_we,      w_mem_we_nxt;
    logic [7:0] r_mem_data_in, w_mem_data_in_nxt;

    logic [8:0] w_end_addr;
    logic       w_in_range;
    logic [2:0] w_step_inc;
    logic [2:0] w_len_ext;

    // Nine-bit sum so that e.g. 255+1 is seen as 256, not wrapped to 0.
    assign w_end_addr = {1'b0, addr} + {7'd0, len};
    assign w_in_range = (addr >= 8'd128) && (w_end_addr <= 9'd223);

    assign w_step_inc = r_step + 3'd1;
    assign w_len_ext  = {1'b0, r_len};

    always_comb begin
        w_state_nxt       = r_state;
        w_step_nxt        = r_step;
        w_len_nxt         = r_len;
        w_busy_nxt        = r_busy;
        w_wready_nxt      = 1'b0;
        w_rdata_nxt       = r_rdata;
        w_rvalid_nxt      = 1'b0;
        w_done_nxt        = 1'b0;
        w_err_nxt         = 1'b0;
        w_mem_address_nxt = 8'd0;
        w_mem_we_nxt      = 1'b0;
        w_mem_data_in_nxt = r_mem_data_in;

        case (r_state)
            ST_IDLE: begin
                w_busy_nxt = 1'b0;
                if (req) begin
                    if (w_in_range) begin
                        w_state_nxt       = rw ? ST_WRITE : ST_READ;
                        w_busy_nxt        = 1'b1;
                        w_len_nxt         = len;
                        w_step_nxt        = 3'd0;
                        w_mem_address_nxt = addr;
                        w_mem_we_nxt      = rw;
                        w_mem_data_in_nxt = wdata;
                        w_wready_nxt      = rw && (len != 2'd0);
                    end else begin
                        w_done_nxt = 1'b1;
                        w_err_nxt  = 1'b1;
                    end
                end
            end

            ST_WRITE: begin
                if (r_step < w_len_ext) begin
                    w_step_nxt        = w_step_inc;
                    w_mem_address_nxt = r_mem_address + 8'd1;
                    w_mem_we_nxt      = 1'b1;
                    w_mem_data_in_nxt = wdata;
                    w_wready_nxt      = (w_step_inc < w_len_ext);
                end else begin
                    // Last beat was written at this edge.
                    w_state_nxt = ST_IDLE;
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                end
            end

            ST_READ: begin
                w_step_nxt = w_step_inc;
                if (r_step < w_len_ext) begin
                    w_mem_address_nxt = r_mem_address + 8'd1;
                end
                // RAM data for the beat issued at Ek is on mem_data_out
                // after E(k+1), so it is captured at E(k+2).
                if (r_step != 3'd0) begin
                    w_rdata_nxt  = mem_data_out;
                    w_rvalid_nxt = 1'b1;
                end
                if (r_step == (w_len_ext + 3'd1)) begin
                    w_state_nxt = ST_IDLE;
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_step        <= 3'd0;
            r_len         <= 2'd0;
            r_busy        <= 1'b0;
            r_wready      <= 1'b0;
            r_rdata       <= 8'd0;
            r_rvalid      <= 1'b0;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
            r_mem_address <= 8'd0;
            r_mem_we      <= 1'b0;
            r_mem_data_in <= 8'd0;
        end else begin
            r_state       <= w_state_nxt;
            r_step        <= w_step_nxt;
            r_len         <= w_len_nxt;
            r_busy        <= w_busy_nxt;
            r_wready      <= w_wready_nxt;
            r_rdata       <= w_rdata_nxt;
            r_rvalid      <= w_rvalid_nxt;
            r_done        <= w_done_nxt;
            r_err         <= w_err_nxt;
            r_mem_address <= w_mem_address_nxt;
            r_mem_we      <= w_mem_we_nxt;
            r_mem_data_in <= w_mem_data_in_nxt;
        end
    end

    assign busy        = r_busy;
    assign wready      = r_wready;
    assign rdata       = r_rdata;
    assign rvalid      = r_rvalid;
    assign done        = r_done;
    assign err         = r_err;
    assign mem_address = r_mem_address;
    assign mem_WE      = r_mem_we;
    assign mem_data_in = r_mem_data_in;

endmodule

// File: doc/mem_master_96x8.md
MEM_MASTER_96X8 -- requirements
Module: mem_master_96x8

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset; all state SHALL change only on the rising edge of clk.
REQ-002 Port clk, input, 1 bit: system clock.
REQ-003 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 Port req, input, 1 bit: transfer request from the control unit, sampled only while busy=0.
REQ-005 Port rw, input, 1 bit: transfer direction; 1=write, 0=read; sampled with req.
REQ-006 Port addr, input, 8 bits: start byte address; sampled with req.
REQ-007 Port len, input, 2 bits: burst length minus one (1-4 beats); sampled with req.
REQ-008 Port wdata, input, 8 bits: write data; beat 0 sampled with req, later beats sampled at the edge ending a wready=1 cycle.
REQ-009 Port busy, output, 1 bit: transfer in progress.
REQ-010 Port wready, output, 1 bit: wdata for the next write beat is consumed at the end of this cycle.
REQ-011 Port rdata, output, 8 bits: read beat data, valid while rvalid=1.
REQ-012 Port rvalid, output, 1 bit: one-cycle pulse per read beat.
REQ-013 Port done, output, 1 bit: one-cycle pulse when a transfer completes or is rejected.
REQ-014 Port err, output, 1 bit: qualifies done; 1=transfer rejected for range violation.
REQ-015 Port mem_address, output, 8 bits: address to the 96x8 synchronous RAM.
REQ-016 Port mem_WE, output, 1 bit: write enable to the RAM.
REQ-017 Port mem_data_in, output, 8 bits: write data to the RAM.
REQ-018 Port mem_data_out, input, 8 bits: RAM read data, registered by the RAM one edge after the address.

Function
REQ-019 All outputs SHALL be registered.
REQ-020 States SHALL be IDLE, READ and WRITE.
REQ-021 When no beat is issued, mem_address SHALL be 0 (outside the RAM window 128..223) and mem_WE SHALL be 0.
REQ-022 In IDLE with req=1 at edge E0, the range check SHALL be addr>=128 and addr+len<=223, computed 9 bits wide with no wrap-around.
REQ-023 On range failure at E0: done=1 and err=1 for one cycle, no RAM access, state remains IDLE, busy stays 0.
REQ-024 On range pass at E0: busy=1, mem_address=addr, mem_WE=rw, mem_data_in=wdata, state=READ or WRITE.
REQ-025 WRITE: at each edge Ek (k=1..len), mem_address increments by 1, mem_data_in takes the sampled wdata, and wready=1 during the cycle preceding each such edge.
REQ-026 WRITE completion: after edge E(len+1), done=1, err=0, busy=0, mem_WE=0, mem_address=0, state=IDLE.
REQ-027 READ: beat k address SHALL be driven after edge Ek; rdata SHALL capture mem_data_out at edge E(k+2), with rvalid=1 for the following cycle.
REQ-028 READ completion: done SHALL pulse in the same cycle as the final rvalid (after edge E(len+2)); busy=0 and state=IDLE in that cycle.
REQ-029 req while busy=1 SHALL be ignored (no queuing).
REQ-030 A new request SHALL be accepted in the cycle done=1 (back-to-back transfers).
REQ-031 rdata SHALL hold its last value when rvalid=0.

Reset
REQ-032 With reset=1 at an edge, state=IDLE and busy, wready, rvalid, done, err, mem_WE=0; mem_address, mem_data_in and rdata=0.
REQ-033 Reset SHALL take priority over req and abort any transfer in progress; no RAM write SHALL occur after the reset edge.

Verification
REQ-034 Single write: req, rw=1, addr=130, len=0, wdata=0x5A -> one cycle of mem_WE=1 at address 130, then done=1, err=0; a subsequent read of 130 returns rdata=0x5A.
REQ-035 Burst read: preload 200..203 with 0x11,0x22,0x33,0x44; read addr=200, len=3 -> four consecutive rvalid pulses with 0x11..0x44, done coincident with the fourth pulse.
REQ-036 Burst write: addr=220, len=3, wdata 0xA0..0xA3 via wready -> RAM 220..223 hold 0xA0..0xA3; done after the fourth write edge.
REQ-037 Range errors: addr=127 len=0, addr=222 len=3, and addr=255 len=1 -> each gives done=1, err=1, and mem_WE and mem_address remain 0.
REQ-038 Reset mid-burst: assert reset during the second beat of a 4-beat write at 160 -> 162..163 unchanged, all outputs at reset values.
REQ-039 Back-to-back and busy-ignore: req held high across two transfers -> the second transfer starts in the done cycle; a req pulse during busy produces no extra transfer.
